key_ctrl: RTL
=============

# key_ctrl

Front-panel input controller for the electronic clock: debounces four raw push-buttons and turns them into the control bus the display driver consumes. Outputs are mode_set (one-hot display mode), mode_seg (steady-on digit mask), flag_s (blink phase), plus edit-field select, inc/dec pulses and stopwatch controls. It sits between the board keys and the clock/date/stopwatch/alarm counters and the seven-segment driver.

## Interface

- DEBOUNCE_CYC, 1_000_000, clk cycles a synchronized key must stay stable before it is accepted (20 ms at 50 MHz).
- BLINK_CYC, 25_000_000, clk cycles per flag_s half-period.
- EDIT_TIMEOUT, 20, flag_s toggles with no accepted key press before edit mode auto-exits.

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- key  in  4  raw buttons, active-low, asynchronous to clk: [0] MODE, [1] SET, [2] UP, [3] DOWN
- mode_set  out  4  one-hot mode: 0001 clock, 0010 date, 0100 stopwatch, 1000 alarm
- mode_seg  out  6  1 = digit always lit; 0 = digit shown only while flag_s=1
- flag_s  out  1  blink phase
- edit  out  1  high while in an edit state
- field_sel  out  2  field being edited: 0 = digits 5:4, 1 = digits 3:2, 2 = digits 1:0
- inc  out  1  one-cycle pulse: increment the selected field
- dec  out  1  one-cycle pulse: decrement the selected field
- sw_run  out  1  stopwatch run level
- sw_clr  out  1  one-cycle pulse: clear the stopwatch

## Operation

- Per key: 2-FF synchronizer s1→s2, debounced state db (reset 1) and counter cnt.
  - cnt clears whenever s2==db.
  - When s2!=db and cnt==DEBOUNCE_CYC-1, db<=s2 and cnt<=0.
  - Press event = registered pulse in the same cycle db goes 1→0. Releases generate no event.
- Same-cycle events use priority SET > MODE > UP > DOWN. Lower-priority events in that cycle are dropped.
- FSM states: IDLE, EDIT0, EDIT1, EDIT2.
- IDLE:
  - MODE rotates mode_set 0001→0010→0100→1000→0001.
  - SET enters EDIT0 unless mode_set==0100. In stopwatch mode SET is ignored.
  - In stopwatch mode, UP toggles sw_run and DOWN pulses sw_clr, but only when sw_run=0. DOWN is ignored while running.
  - Outside stopwatch mode, UP and DOWN are ignored.
- EDITn:
  - SET advances EDIT0→EDIT1→EDIT2→IDLE.
  - UP pulses inc; DOWN pulses dec.
  - MODE is ignored.
  - EDIT_TIMEOUT consecutive flag_s toggles without any accepted press → IDLE.
- Outputs per state:
  - edit=1 in EDITn.
  - field_sel=n in EDITn and holds its last value in IDLE.
  - mode_seg: IDLE 111111, EDIT0 001111, EDIT1 110011, EDIT2 111100.
- Blink:
  - Counter 0..BLINK_CYC-1 free-runs; flag_s toggles at wrap.
  - On entry to any EDITn, the counter clears and flag_s<=1, so the edited digits are visible immediately.
  - The timeout counter clears on any accepted press and on state entry.
- mode_set changes only from IDLE, so a mode change never happens while editing.

## Timing

- Reset values: mode_set 0001, mode_seg 111111, flag_s 1, edit 0, field_sel 0, inc 0, dec 0, sw_run 0, sw_clr 0; all counters 0, all db 1.
- Latency from key first sampled low to db fall / press event: exactly DEBOUNCE_CYC+2 clk edges, provided key stays low throughout.
- Glitches shorter than DEBOUNCE_CYC cycles at s2 produce no event.
- All outputs are registered and update on the clk edge following the press-event cycle.
- inc, dec and sw_clr are high for exactly one cycle per press. Holding a key does not repeat.
- Reset asserted mid-edit returns the block immediately (asynchronously) to all reset values. The first press after rst_n deasserts needs a full debounce period.

## Test plan

Bench parameters: DEBOUNCE_CYC=4, BLINK_CYC=8, EDIT_TIMEOUT=3.

- Reset, then press MODE four times with clean presses and releases → mode_set 0010, 0100, 1000, 0001. Each change occurs DEBOUNCE_CYC+3 edges after key low.
- 2-cycle low glitch on SET → no state change. Then a 6-cycle low on SET → edit=1, mode_seg=001111, flag_s=1.
- In EDIT1, press UP twice and DOWN once → exactly two inc pulses and one dec pulse, each 1 cycle wide, with field_sel=1 throughout.
- Press SET and MODE in the same cycle from IDLE in clock mode → EDIT0 entered, mode_set stays 0001.
- In stopwatch mode: UP → sw_run=1. Then DOWN → no sw_clr. Then UP → sw_run=0. Then DOWN → one sw_clr pulse. SET ignored throughout.
- Enter EDIT2 and wait 3×8 cycles idle → state IDLE, mode_seg=111111. Separately, assert rst_n low in EDIT1 → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/key_ctrl.sv
// Front-panel key controller: debounces four active-low buttons and drives the
// display mode, edit-field, blink and stopwatch control bus.
module key_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned BLINK_CYC    = 25_000_000,
  parameter int unsigned EDIT_TIMEOUT = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  output logic [3:0] mode_set,
  output logic [5:0] mode_seg,
  output logic       flag_s,
  output logic       edit,
  output logic [1:0] field_sel,
  output logic       inc,
  output logic       dec,
  output logic       sw_run,
  output logic       sw_clr
);

  localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned BL_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam int unsigned TO_W = $clog2(EDIT_TIMEOUT + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(EDIT_TIMEOUT - 1);
  localparam logic [3:0] MODE_SW = 4'b0100;

  typedef enum logic [1:0] {IDLE, EDIT0, EDIT1, EDIT2} state_t;

  logic [3:0]            s1, s2, db, press;
  logic [3:0][DB_W-1:0]  cnt;

  // Synchronizer + debounce; press fires in the cycle db falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '1;
      s2    <= '1;
      db    <= '1;
      press <= '0;
      cnt   <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]    <= s2[i];
          cnt[i]   <= '0;
          press[i] <= ~s2[i];
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic ev_mode, ev_set, ev_up, ev_dn;

  // Single winning event per cycle: SET > MODE > UP > DOWN
  always_comb begin
    ev_set  = press[1];
    ev_mode = press[0] & ~press[1];
    ev_up   = press[2] & ~press[1] & ~press[0];
    ev_dn   = press[3] & ~(|press[2:0]);
  end

  state_t            state, state_d;
  logic [3:0]        mode_set_d;
  logic [5:0]        mode_seg_d;
  logic              flag_d, edit_d, inc_d, dec_d, sw_run_d, sw_clr_d;
  logic [1:0]        field_sel_d;
  logic [BL_W-1:0]   blink_cnt, blink_cnt_d;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic              blink_wrap;

  always_comb begin
    state_d     = state;
    mode_set_d  = mode_set;
    field_sel_d = field_sel;
    sw_run_d    = sw_run;
    inc_d       = 1'b0;
    dec_d       = 1'b0;
    sw_clr_d    = 1'b0;
    edit_d      = 1'b0;
    mode_seg_d  = 6'b111111;
    blink_wrap  = (blink_cnt == BL_LAST);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt + BL_W'(1);
    flag_d      = blink_wrap ? ~flag_s : flag_s;
    to_cnt_d    = to_cnt;

    case (state)
      IDLE: begin
        to_cnt_d = '0;
        if (ev_set) begin
          if (mode_set != MODE_SW) state_d = EDIT0;
        end else if (ev_mode) begin
          mode_set_d = {mode_set[2:0], mode_set[3]};
        end else if (mode_set == MODE_SW) begin
          if (ev_up)                sw_run_d = ~sw_run;
          else if (ev_dn && !sw_run) sw_clr_d = 1'b1;
        end
      end
      default: begin
        if (ev_set) begin
          case (state)
            EDIT0:   state_d = EDIT1;
            EDIT1:   state_d = EDIT2;
            default: state_d = IDLE;
          endcase
        end else if (ev_up || ev_dn) begin
          inc_d    = ev_up;
          dec_d    = ev_dn;
          to_cnt_d = '0;
        end else if (blink_wrap) begin
          if (to_cnt == TO_LAST) state_d = IDLE;
          else                   to_cnt_d = to_cnt + TO_W'(1);
        end
      end
    endcase

    // Any state entry restarts the timeout; entering an edit state shows the digits at once
    if (state_d != state) begin
      to_cnt_d = '0;
      if (state_d != IDLE) begin
        blink_cnt_d = '0;
        flag_d      = 1'b1;
      end
    end

    case (state_d)
      EDIT0: begin edit_d = 1'b1; field_sel_d = 2'd0; mode_seg_d = 6'b001111; end
      EDIT1: begin edit_d = 1'b1; field_sel_d = 2'd1; mode_seg_d = 6'b110011; end
      EDIT2: begin edit_d = 1'b1; field_sel_d = 2'd2; mode_seg_d = 6'b111100; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_set  <= 4'b0001;
      mode_seg  <= 6'b111111;
      flag_s    <= 1'b1;
      edit      <= 1'b0;
      field_sel <= 2'd0;
      inc       <= 1'b0;
      dec       <= 1'b0;
      sw_run    <= 1'b0;
      sw_clr    <= 1'b0;
      blink_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      state     <= state_d;
      mode_set  <= mode_set_d;
      mode_seg  <= mode_seg_d;
      flag_s    <= flag_d;
      edit      <= edit_d;
      field_sel <= field_sel_d;
      inc       <= inc_d;
      dec       <= dec_d;
      sw_run    <= sw_run_d;
      sw_clr    <= sw_clr_d;
      blink_cnt <= blink_cnt_d;
      to_cnt    <= to_cnt_d;
    end
  end

endmodule
